rf_wb_arbiter: RTL and testbench

Write-back arbiter for the integer register file's single write port. It accepts write requests from `N_REQ` producers (ALU, load unit, CSR unit, …) over a valid/ready handshake. It grants one requester per cycle in round-robin order and drives the register file's write port from a one-cycle output register. An optional bypass path forwards the in-flight write to the two read ports.

---
 rtl/rf_wb_arbiter.sv | 110 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the RF write port; the winner reaches the RF one cycle after its handshake.
// Never back-pressures itself; i_hold blocks every grant. `RF_WB_BYPASS_EN forwards the in-flight write to the read ports.
module rf_wb_arbiter #(
   parameter int N_REQ    = 3,
   parameter int ADDR_NBW = 5,
   parameter int DATA_NBW = 32
) (
   input  logic                      clk,
   input  logic                      rst_async_n,
   input  logic                      i_hold,
   input  logic [N_REQ-1:0]          i_req_vld,
   input  logic [N_REQ*ADDR_NBW-1:0] i_req_addr,
   input  logic [N_REQ*DATA_NBW-1:0] i_req_dt,
   output logic [N_REQ-1:0]          o_req_rdy,
   output logic                      o_rf_wr_en,
   output logic [ADDR_NBW-1:0]       o_rf_wr_addr,
   output logic [DATA_NBW-1:0]       o_rf_wr_dt,
   input  logic [ADDR_NBW-1:0]       i_rd_addr_1,
   input  logic [ADDR_NBW-1:0]       i_rd_addr_2,
   input  logic [DATA_NBW-1:0]       i_rf_rd_dt_1,
   input  logic [DATA_NBW-1:0]       i_rf_rd_dt_2,
   output logic [DATA_NBW-1:0]       o_rd_dt_1,
   output logic [DATA_NBW-1:0]       o_rd_dt_2
);

   localparam int PTR_NBW = $clog2(N_REQ);

   logic [PTR_NBW-1:0]  rr_ptr_q, rr_ptr_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_NBW-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_NBW-1:0] wr_dt_q, wr_dt_d;

   logic [ADDR_NBW-1:0] req_addr_a [N_REQ];
   logic [DATA_NBW-1:0] req_dt_a   [N_REQ];

   logic [N_REQ-1:0]    gnt;
   logic                gnt_found;
   logic [PTR_NBW-1:0]  gnt_idx;
   logic [PTR_NBW:0]    idx;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_addr_a[gi] = i_req_addr[gi*ADDR_NBW +: ADDR_NBW];
      assign req_dt_a[gi]   = i_req_dt[gi*DATA_NBW +: DATA_NBW];
   end

   // Search from rr_ptr upward, wrapping modulo N_REQ; the first valid requester wins.
   always_comb begin
      gnt       = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (PTR_NBW+1)'(k);
         if (idx >= (PTR_NBW+1)'(N_REQ)) begin
            idx = idx - (PTR_NBW+1)'(N_REQ);
         end
         if (!gnt_found && !i_hold && i_req_vld[idx[PTR_NBW-1:0]]) begin
            gnt[idx[PTR_NBW-1:0]] = 1'b1;
            gnt_idx               = idx[PTR_NBW-1:0];
            gnt_found             = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_dt_d   = wr_dt_q;
      if (gnt_found) begin
         rr_ptr_d  = (gnt_idx == PTR_NBW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
         // x0 writes are consumed but never issued to the RF.
         wr_en_d   = (req_addr_a[gnt_idx] != '0);
         wr_addr_d = req_addr_a[gnt_idx];
         wr_dt_d   = req_dt_a[gnt_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         rr_ptr_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_dt_q   <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_dt_q   <= wr_dt_d;
      end
   end

   assign o_req_rdy    = gnt;
   assign o_rf_wr_en   = wr_en_q;
   assign o_rf_wr_addr = wr_addr_q;
   assign o_rf_wr_dt   = wr_dt_q;

`ifdef RF_WB_BYPASS_EN
   // The RF captures the write only at the end of this cycle, so forward it here.
   assign o_rd_dt_1 = (wr_en_q && (wr_addr_q == i_rd_addr_1)) ? wr_dt_q : i_rf_rd_dt_1;
   assign o_rd_dt_2 = (wr_en_q && (wr_addr_q == i_rd_addr_2)) ? wr_dt_q : i_rf_rd_dt_2;
`else
   assign o_rd_dt_1 = i_rf_rd_dt_1;
   assign o_rd_dt_2 = i_rf_rd_dt_2;

   logic unused_rd_addr;
   assign unused_rd_addr = ^{i_rd_addr_1, i_rd_addr_2};
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: the driver pushes expected RF writes, a monitor pops them as o_rf_wr_en appears.
module tb_rf_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk;
   logic            rst_async_n;
   logic            i_hold;
   logic [N-1:0]    i_req_vld;
   logic [N*AW-1:0] i_req_addr;
   logic [N*DW-1:0] i_req_dt;
   logic [N-1:0]    o_req_rdy;
   logic            o_rf_wr_en;
   logic [AW-1:0]   o_rf_wr_addr;
   logic [DW-1:0]   o_rf_wr_dt;
   logic [AW-1:0]   i_rd_addr_1, i_rd_addr_2;
   logic [DW-1:0]   i_rf_rd_dt_1, i_rf_rd_dt_2;
   logic [DW-1:0]   o_rd_dt_1, o_rd_dt_2;

   rf_wb_arbiter #(.N_REQ(N), .ADDR_NBW(AW), .DATA_NBW(DW)) dut (
      .clk          (clk),
      .rst_async_n  (rst_async_n),
      .i_hold       (i_hold),
      .i_req_vld    (i_req_vld),
      .i_req_addr   (i_req_addr),
      .i_req_dt     (i_req_dt),
      .o_req_rdy    (o_req_rdy),
      .o_rf_wr_en   (o_rf_wr_en),
      .o_rf_wr_addr (o_rf_wr_addr),
      .o_rf_wr_dt   (o_rf_wr_dt),
      .i_rd_addr_1  (i_rd_addr_1),
      .i_rd_addr_2  (i_rd_addr_2),
      .i_rf_rd_dt_1 (i_rf_rd_dt_1),
      .i_rf_rd_dt_2 (i_rf_rd_dt_2),
      .o_rd_dt_1    (o_rd_dt_1),
      .o_rd_dt_2    (o_rd_dt_2)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           exp_q [$];
   logic [AW-1:0] req_addr [N];
   logic [DW-1:0] req_dt   [N];
   int            n_chk  = 0;
   int            n_pass = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One cycle of stimulus: drive at the falling edge, check the grant, queue the expected RF write.
   task automatic step(input logic hold, input logic [N-1:0] vld, input logic [N-1:0] exp_rdy, input string name);
      wr_t w;
      @(negedge clk);
      i_hold     = hold;
      i_req_vld  = vld;
      i_req_addr = {req_addr[2], req_addr[1], req_addr[0]};
      i_req_dt   = {req_dt[2], req_dt[1], req_dt[0]};
      #1;
      chk(name, 64'(o_req_rdy), 64'(exp_rdy));
      for (int i = 0; i < N; i++) begin
         if (exp_rdy[i] && req_addr[i] != '0) begin
            w.a = req_addr[i];
            w.d = req_dt[i];
            exp_q.push_back(w);
         end
      end
   endtask

   task automatic chk_ptr(input logic [1:0] exp, input string name);
      @(posedge clk);
      #3;
      chk(name, 64'(dut.rr_ptr_q), 64'(exp));
   endtask

   // Monitor: every issued RF write must match the oldest expected write.
   initial begin
      wr_t w;
      forever begin
         @(posedge clk);
         #2;
         if (o_rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL rf_write: unexpected write addr=%0d dt=0x%0h, expected none", o_rf_wr_addr, o_rf_wr_dt);
            end else begin
               w = exp_q.pop_front();
               chk("rf_wr_addr", 64'(o_rf_wr_addr), 64'(w.a));
               chk("rf_wr_dt", 64'(o_rf_wr_dt), 64'(w.d));
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] exp_byp;
      rst_async_n  = 1'b0;
      i_hold       = 1'b0;
      i_req_vld    = '0;
      i_req_addr   = '0;
      i_req_dt     = '0;
      i_rd_addr_1  = 5'd1;
      i_rd_addr_2  = 5'd2;
      i_rf_rd_dt_1 = 32'h1111_1111;
      i_rf_rd_dt_2 = 32'h2222_2222;
      for (int i = 0; i < N; i++) begin
         req_addr[i] = '0;
         req_dt[i]   = '0;
      end
      #3;
      chk("rst_rdy", 64'(o_req_rdy), 64'(0));
      chk("rst_wr_en", 64'(o_rf_wr_en), 64'(0));
      chk("rst_wr_addr", 64'(o_rf_wr_addr), 64'(0));
      chk("rst_wr_dt", 64'(o_rf_wr_dt), 64'(0));
      chk("rst_rd_dt_1", 64'(o_rd_dt_1), 64'(32'h1111_1111));
      chk("rst_ptr", 64'(dut.rr_ptr_q), 64'(0));
      @(negedge clk);
      rst_async_n = 1'b1;

      // All three valid for six cycles.
      req_addr[0] = 5'd10; req_dt[0] = 32'h0000_00A0;
      req_addr[1] = 5'd11; req_dt[1] = 32'h0000_00B1;
      req_addr[2] = 5'd12; req_dt[2] = 32'h0000_00C2;
      step(1'b0, 3'b111, 3'b001, "rr_gnt0");
      step(1'b0, 3'b111, 3'b010, "rr_gnt1");
      step(1'b0, 3'b111, 3'b100, "rr_gnt2");
      step(1'b0, 3'b111, 3'b001, "rr_gnt3");
      step(1'b0, 3'b111, 3'b010, "rr_gnt4");
      step(1'b0, 3'b111, 3'b100, "rr_gnt5");
      chk_ptr(2'd0, "rr_ptr_wrap");

      // Single write from requester 1.
      req_addr[1] = 5'd5; req_dt[1] = 32'hDEAD_BEEF;
      step(1'b0, 3'b010, 3'b010, "single_rdy");
      chk_ptr(2'd2, "single_ptr");
      chk("single_wr_en", 64'(o_rf_wr_en), 64'(1));

      // x0 write: consumed, pointer advances, never issued.
      req_addr[0] = 5'd0; req_dt[0] = 32'h0000_1234;
      step(1'b0, 3'b001, 3'b001, "x0_rdy");
      chk_ptr(2'd1, "x0_ptr");
      chk("x0_wr_en", 64'(o_rf_wr_en), 64'(0));

      step(1'b0, 3'b100, 3'b100, "req2_rdy");
      chk_ptr(2'd0, "req2_ptr");

      // Hold blocks grants and freezes the pointer.
      req_addr[0] = 5'd3; req_dt[0] = 32'h0000_0033;
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 3'b101, 3'b000, "hold_rdy");
         chk_ptr(2'd0, "hold_ptr");
      end
      step(1'b0, 3'b101, 3'b001, "release_gnt0");
      step(1'b0, 3'b100, 3'b100, "release_gnt2");
      chk_ptr(2'd0, "release_ptr");

      // Bypass of an in-flight write.
      req_addr[1] = 5'd7; req_dt[1] = 32'hA5A5_A5A5;
      step(1'b0, 3'b010, 3'b010, "byp_rdy");
      @(negedge clk);
      i_req_vld    = '0;
      i_rd_addr_1  = 5'd7;
      i_rf_rd_dt_1 = 32'h0;
      i_rd_addr_2  = 5'd3;
      i_rf_rd_dt_2 = 32'h0000_2222;
      #1;
`ifdef RF_WB_BYPASS_EN
      exp_byp = 32'hA5A5_A5A5;
`else
      exp_byp = 32'h0;
`endif
      chk("byp_rd_dt_1", 64'(o_rd_dt_1), 64'(exp_byp));
      chk("byp_rd_dt_2", 64'(o_rd_dt_2), 64'(32'h0000_2222));
      step(1'b0, 3'b000, 3'b000, "idle_rdy");
      chk("nobyp_rd_dt_1", 64'(o_rd_dt_1), 64'(0));

      // Asynchronous reset while a write is registered.
      req_addr[0] = 5'd9; req_dt[0] = 32'h0000_CAFE;
      step(1'b0, 3'b001, 3'b001, "prerst_rdy");
      @(posedge clk);
      #3;
      i_req_vld   = '0;
      rst_async_n = 1'b0;
      #1;
      chk("arst_wr_en", 64'(o_rf_wr_en), 64'(0));
      chk("arst_wr_addr", 64'(o_rf_wr_addr), 64'(0));
      chk("arst_wr_dt", 64'(o_rf_wr_dt), 64'(0));
      chk("arst_ptr", 64'(dut.rr_ptr_q), 64'(0));
      @(negedge clk);
      rst_async_n = 1'b1;
      req_addr[0] = 5'd20; req_dt[0] = 32'h0000_0D00;
      req_addr[1] = 5'd21; req_dt[1] = 32'h0000_0D01;
      req_addr[2] = 5'd22; req_dt[2] = 32'h0000_0D02;
      step(1'b0, 3'b111, 3'b001, "postrst_gnt0");
      step(1'b0, 3'b110, 3'b010, "postrst_gnt1");
      step(1'b0, 3'b000, 3'b000, "final_idle");
      step(1'b0, 3'b000, 3'b000, "final_idle");
      chk("sb_empty", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
